dmem_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer for the single-port data memory (data_memory).

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 34 +++
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester id, helpers.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    ACK
  } dmem_arb_state_t;

  // 0 = CPU load/store, 1 = loader/debug
  typedef logic port_id_t;

  localparam int unsigned NUM_REQ = 2;

  function automatic port_id_t other_port(port_id_t p);
    return ~p;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker. Purely combinational; the caller owns last_grant.
// exclude_* masks one requester out (used to ignore the port being acked).
module rr_arbiter2
  import dmem_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  port_id_t           last_grant,
  input  logic               exclude_valid,
  input  port_id_t           exclude_id,
  output logic               gnt_valid,
  output port_id_t           gnt_id
);

  logic [NUM_REQ-1:0] excl_mask;
  logic [NUM_REQ-1:0] req_m;

  // Mask the excluded port, then grant the lone requester or alternate on contention
  always_comb begin
    excl_mask = '0;
    if (exclude_valid) begin
      excl_mask[exclude_id] = 1'b1;
    end
    req_m     = req & ~excl_mask;
    gnt_valid = |req_m;
    gnt_id    = 1'b0;
    case (req_m)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = other_port(last_grant);
      default: gnt_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer in front of the single-port data memory. One transaction in
// flight, fixed IDLE/ACK -> ISSUE -> CAPTURE -> ACK sequence (3 cycles accept-to-ack).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned W = 32,
  parameter int unsigned N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic         we0,
  input  logic         we1,
  input  logic [N-1:0] addr0,
  input  logic [N-1:0] addr1,
  input  logic [W-1:0] wdata0,
  input  logic [W-1:0] wdata1,
  output logic         ack0,
  output logic         ack1,
  output logic [W-1:0] rdata0,
  output logic [W-1:0] rdata1,
  output logic [N-1:0] mem_addr,
  output logic         mem_read,
  output logic         mem_write,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata,
  output logic         busy
);

  dmem_arb_state_t state_q, state_d;
  port_id_t        owner_q, owner_d;
  port_id_t        last_grant_q, last_grant_d;
  logic            we_q, we_d;
  logic [N-1:0]    addr_q, addr_d;
  logic [W-1:0]    wdata_q, wdata_d;
  logic [W-1:0]    rdata0_q, rdata0_d;
  logic [W-1:0]    rdata1_q, rdata1_d;

  logic            gnt_valid;
  port_id_t        gnt_id;
  logic            latch;
  logic            sel_we;
  logic [N-1:0]    sel_addr;
  logic [W-1:0]    sel_wdata;

  // In ACK the current owner is excluded so the other port gets the back-to-back slot
  rr_arbiter2 u_rr (
    .req           ({req1, req0}),
    .last_grant    (last_grant_q),
    .exclude_valid (state_q == ACK),
    .exclude_id    (owner_q),
    .gnt_valid     (gnt_valid),
    .gnt_id        (gnt_id)
  );

  // Command fields of the granted port
  always_comb begin
    sel_we    = we0;
    sel_addr  = addr0;
    sel_wdata = wdata0;
    if (gnt_id) begin
      sel_we    = we1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end
  end

  // Next-state, command latch and read-data capture
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    latch        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          latch   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        // Memory read data is valid the cycle after mem_read was sampled
        if (!we_q) begin
          if (owner_q) begin
            rdata1_d = mem_rdata;
          end else begin
            rdata0_d = mem_rdata;
          end
        end
        state_d = ACK;
      end
      ACK: begin
        if (gnt_valid) begin
          latch   = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (latch) begin
      owner_d      = gnt_id;
      last_grant_d = gnt_id;
      we_d         = sel_we;
      addr_d       = sel_addr;
      wdata_d      = sel_wdata;
    end
  end

  // State and datapath registers; last_grant resets to 1 so port 0 wins first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Outputs decoded from state; addr_q/wdata_q only change on entry to ISSUE,
  // so mem_addr/mem_wdata hold their last value outside ISSUE
  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_write = (state_q == ISSUE) && we_q;
    mem_read  = (state_q == ISSUE) && !we_q;
    ack0      = (state_q == ACK) && (owner_q == 1'b0);
    ack1      = (state_q == ACK) && (owner_q == 1'b1);
    busy      = (state_q != IDLE);
    rdata0    = rdata0_q;
    rdata1    = rdata1_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory, directed scenarios, random traffic,
// and a scoreboard monitor with a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int unsigned W     = 32;
  localparam int unsigned N     = 5;
  localparam int unsigned DEPTH = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1, we0, we1;
  logic [N-1:0] addr0, addr1;
  logic [W-1:0] wdata0, wdata1;
  logic         ack0, ack1;
  logic [W-1:0] rdata0, rdata1;
  logic [N-1:0] mem_addr;
  logic         mem_read, mem_write;
  logic [W-1:0] mem_wdata, mem_rdata;
  logic         busy;

  always #5 clk = ~clk;

  dmem_arbiter #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Single-port memory: synchronous write, registered read, plus a preload path
  logic [W-1:0] mem [DEPTH];
  logic         preload;
  logic [N-1:0] pl_addr;
  logic [W-1:0] pl_data;
  always @(posedge clk) begin
    if (preload) mem[pl_addr] <= pl_data;
    else if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read) mem_rdata <= mem[mem_addr];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic         we;
    logic [N-1:0] addr;
    logic [W-1:0] wdata;
  } txn_t;

  txn_t         q0[$];
  txn_t         q1[$];
  logic [W-1:0] ref_mem [DEPTH];
  int           log_port[$];
  int unsigned  log_cyc[$];
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic check_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor. Reference rules: an idle arbiter accepts a request seen in
  // cycle t and acks it at t+3 (strobes at t+1); at an ack the other port, if
  // requesting, is accepted; on contention the port not granted last wins.
  initial begin : monitor
    bit           m_active;
    bit           m_port;
    bit           m_last;
    bit           e_ack, e_iss, c0, c1, pick;
    int unsigned  m_acc;
    txn_t         m_cmd;
    logic [W-1:0] m_rdata [2];
    m_active = 1'b0; m_port = 1'b0; m_last = 1'b1; m_acc = 0; m_cmd = '0;
    m_rdata[0] = '0; m_rdata[1] = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        check_b("rst_ack0", ack0, 1'b0);
        check_b("rst_ack1", ack1, 1'b0);
        check_b("rst_busy", busy, 1'b0);
        check_b("rst_mem_read", mem_read, 1'b0);
        check_b("rst_mem_write", mem_write, 1'b0);
        check_w("rst_mem_addr", W'(mem_addr), '0);
        check_w("rst_mem_wdata", mem_wdata, '0);
        check_w("rst_rdata0", rdata0, '0);
        check_w("rst_rdata1", rdata1, '0);
        m_active = 1'b0; m_last = 1'b1;
        m_rdata[0] = '0; m_rdata[1] = '0;
        q0.delete(); q1.delete();
      end else begin
        e_iss = m_active && (cyc == m_acc + 1);
        e_ack = m_active && (cyc == m_acc + 3);
        check_b("busy", busy, m_active && (cyc > m_acc));
        check_b("mem_write", mem_write, e_iss && m_cmd.we);
        check_b("mem_read", mem_read, e_iss && !m_cmd.we);
        if (e_iss) begin
          check_w("mem_addr", W'(mem_addr), W'(m_cmd.addr));
          if (m_cmd.we) check_w("mem_wdata", mem_wdata, m_cmd.wdata);
        end
        check_b("ack0", ack0, e_ack && !m_port);
        check_b("ack1", ack1, e_ack && m_port);
        if (e_ack) begin
          if (m_cmd.we) ref_mem[m_cmd.addr] = m_cmd.wdata;
          else m_rdata[m_port] = ref_mem[m_cmd.addr];
          log_port.push_back(int'(m_port));
          log_cyc.push_back(cyc);
          if (m_port) begin
            if (q1.size() > 0) void'(q1.pop_front());
          end else begin
            if (q0.size() > 0) void'(q0.pop_front());
          end
        end
        check_w("rdata0", rdata0, m_rdata[0]);
        check_w("rdata1", rdata1, m_rdata[1]);
        if (!m_active || e_ack) begin
          c0 = (req0 === 1'b1) && !(e_ack && !m_port);
          c1 = (req1 === 1'b1) && !(e_ack && m_port);
          pick = (c0 && c1) ? !m_last : c1;
          m_active = c0 || c1;
          if (m_active) begin
            m_port = pick;
            m_last = pick;
            m_acc  = cyc;
            if (pick) m_cmd = (q1.size() > 0) ? q1[0] : '0;
            else m_cmd = (q0.size() > 0) ? q0[0] : '0;
          end
        end
      end
    end
  end

  // Present a command on port p (call at posedge+1), wait for its ack, return
  // at the following posedge+1. lat = cycles from first sampled request to ack.
  task automatic do_txn(input bit p, input bit we, input logic [N-1:0] a,
                        input logic [W-1:0] d, output int unsigned lat, input bit keep);
    txn_t        t;
    bit          got;
    int unsigned c0;
    t = '{we: we, addr: a, wdata: d};
    if (!p) begin
      we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1; q0.push_back(t);
    end else begin
      we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1; q1.push_back(t);
    end
    got = 1'b0; lat = 0; c0 = 0;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      if (n == 0) c0 = cyc;
      got = p ? ack1 : ack0;
      lat = cyc - c0;
    end
    check_b("ack_wait", got, 1'b1);
    @(posedge clk);
    #1;
    if (!keep) begin
      if (!p) req0 = 1'b0;
      else req1 = 1'b0;
    end
  endtask

  task automatic rand_port(input bit p, input int k);
    int unsigned lat;
    bit          keep;
    int          a;
    for (int i = 0; i < k; i++) begin
      keep = (i < k - 1) && ($urandom_range(0, 1) == 1);
      a = int'($urandom_range(0, 7));
      if (a > 3) a = a + 24;
      do_txn(p, $urandom_range(0, 1) == 1, N'(a), $urandom, lat, keep);
      if (!keep) repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "timeout");
  end

  initial begin : main
    int unsigned  lat, lat_b;
    int           base;
    logic [W-1:0] old7;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    preload = 1'b0; pl_addr = '0; pl_data = '0;
    #1 rst = 1'b0;

    // Reset held with random inputs; memory preloaded meanwhile
    for (int i = 0; i < int'(DEPTH); i++) begin
      @(posedge clk);
      #1;
      preload = 1'b1; pl_addr = N'(i); pl_data = $urandom; ref_mem[i] = pl_data;
      req0 = $urandom_range(0, 1) == 1; req1 = $urandom_range(0, 1) == 1;
      we0 = $urandom_range(0, 1) == 1; we1 = $urandom_range(0, 1) == 1;
      addr0 = N'($urandom); addr1 = N'($urandom); wdata0 = $urandom; wdata1 = $urandom;
    end
    @(posedge clk);
    #1;
    preload = 1'b0; req0 = 1'b0; req1 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Simultaneous reads from reset: port 0 first, port 1 three cycles later
    base = log_port.size();
    fork
      do_txn(1'b0, 1'b0, N'(1), '0, lat, 1'b0);
      do_txn(1'b1, 1'b0, N'(2), '0, lat_b, 1'b0);
    join
    check_w("first_winner", W'(log_port[base]), 0);
    check_w("second_winner", W'(log_port[base+1]), 1);
    check_w("contend_gap", log_cyc[base+1] - log_cyc[base], 3);
    check_w("contend_rdata1", rdata1, ref_mem[2]);
    check_w("contend_rdata0", rdata0, ref_mem[1]);

    // Port 0 write then read of addr 3
    do_txn(1'b0, 1'b1, N'(3), 32'hDEAD_BEEF, lat, 1'b1);
    check_w("wr_latency", lat, 3);
    do_txn(1'b0, 1'b0, N'(3), '0, lat, 1'b0);
    check_w("rd_latency", lat, 3);
    check_w("rd_deadbeef", rdata0, 32'hDEAD_BEEF);

    // Both held for six transactions: strict alternation, 3 cycles apart
    base = log_port.size();
    fork
      for (int i = 0; i < 3; i++) do_txn(1'b0, 1'($urandom), N'($urandom), $urandom, lat, i < 2);
      for (int i = 0; i < 3; i++) do_txn(1'b1, 1'($urandom), N'($urandom), $urandom, lat_b, i < 2);
    join
    for (int i = 1; i < 6; i++) begin
      check_b("alternate", log_port[base+i] != log_port[base+i-1], 1'b1);
      check_w("b2b_spacing", log_cyc[base+i] - log_cyc[base+i-1], 3);
    end

    // Top-address write by port 1, read back by port 0
    do_txn(1'b1, 1'b1, N'(31), 32'h1234_5678, lat, 1'b0);
    do_txn(1'b0, 1'b0, N'(31), '0, lat, 1'b0);
    check_w("wrap_rdata0", rdata0, 32'h1234_5678);

    // Reset during ISSUE of a write to addr 7 abandons it
    old7 = ref_mem[7];
    we0 = 1'b1; addr0 = N'(7); wdata0 = '1; req0 = 1'b1;
    q0.push_back('{we: 1'b1, addr: N'(7), wdata: '1});
    @(negedge clk);
    @(negedge clk);
    #1;
    check_b("issue_write", mem_write, 1'b1);
    rst = 1'b0;
    #1;
    check_b("rst_drops_write", mem_write, 1'b0);
    check_b("rst_drops_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    req0 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    do_txn(1'b0, 1'b0, N'(7), '0, lat, 1'b0);
    check_w("abandoned_write", rdata0, old7);

    // Random two-port traffic
    fork
      rand_port(1'b0, 30);
      rand_port(1'b1, 30);
    join
    repeat (6) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
